// File: rtl/oled_pkg.sv
// Shared SSD1306 command constants, panel geometry and sequencer state encoding.
// Imported by the page streamer, the init sequencer and the SPI driver.
package oled_pkg;

    localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;

    localparam int OLED_COLS  = 128;
    localparam int OLED_PAGES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_PG,
        ST_CMD_CL,
        ST_CMD_CH,
        ST_RD,
        ST_WT,
        ST_SEND,
        ST_DONE
    } oled_state_t;

endpackage

// File: rtl/oled_page_streamer.sv
// Framebuffer-to-SPI byte streamer: per page, 3 addressing commands (dc=0) then COLS pixel bytes (dc=1).
// Latency: command bytes >=1 cycle each, data bytes >=3 cycles each (read, wait, send); frame_done 1 cycle after last data handshake.
// Backpressure: byte_valid/data/dc registered and held until byte_ready; stalls indefinitely. OLED_STREAM_CONT_EN: continuous refresh.
module oled_page_streamer
    import oled_pkg::*;
#(
    parameter int COLS       = OLED_COLS,
    parameter int PAGES      = OLED_PAGES,
    parameter int COL_OFFSET = 0,
    parameter int AW         = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    output logic          fb_rd_en,
    output logic [AW-1:0] fb_addr,
    input  logic [7:0]    fb_rdata,
    output logic          byte_valid,
    output logic [7:0]    byte_data,
    output logic          byte_dc,
    input  logic          byte_ready
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
    localparam logic [PW-1:0] PAGE_LAST   = PW'(PAGES - 1);
    localparam logic [7:0]    COL_LO_BYTE = CMD_COL_LO | 8'(COL_OFFSET & 15);
    localparam logic [7:0]    COL_HI_BYTE = CMD_COL_HI | 8'(COL_OFFSET >> 4);

    oled_state_t   state;
    logic [CW-1:0] col;
    logic [PW-1:0] page;
    logic          xfer;

    assign xfer = byte_valid && byte_ready;

    // Constant multiplier; reduces to a shift when COLS is a power of two.
    function automatic logic [AW-1:0] pix_addr(input logic [PW-1:0] p, input logic [CW-1:0] c);
        return AW'(p) * AW'(COLS) + AW'(c);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            col        <= '0;
            page       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            fb_rd_en   <= 1'b0;
            fb_addr    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_dc    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            fb_rd_en   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        page       <= '0;
                        col        <= '0;
                        busy       <= 1'b1;
                        byte_valid <= 1'b1;
                        byte_dc    <= 1'b0;
                        byte_data  <= CMD_SET_PAGE;
                        state      <= ST_CMD_PG;
                    end
                end
                ST_CMD_PG: begin
                    if (xfer) begin
                        byte_data <= COL_LO_BYTE;
                        state     <= ST_CMD_CL;
                    end
                end
                ST_CMD_CL: begin
                    if (xfer) begin
                        byte_data <= COL_HI_BYTE;
                        state     <= ST_CMD_CH;
                    end
                end
                ST_CMD_CH: begin
                    if (xfer) begin
                        byte_valid <= 1'b0;
                        col        <= '0;
                        fb_rd_en   <= 1'b1;
                        fb_addr    <= pix_addr(page, '0);
                        state      <= ST_RD;
                    end
                end
                ST_RD: begin
                    state <= ST_WT;
                end
                ST_WT: begin
                    byte_data  <= fb_rdata;
                    byte_dc    <= 1'b1;
                    byte_valid <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (col != COL_LAST) begin
                            col        <= col + 1'b1;
                            fb_rd_en   <= 1'b1;
                            fb_addr    <= pix_addr(page, col + 1'b1);
                            byte_valid <= 1'b0;
                            state      <= ST_RD;
                        end else if (page != PAGE_LAST) begin
                            page      <= page + 1'b1;
                            byte_data <= CMD_SET_PAGE | 8'(page + 1'b1);
                            byte_dc   <= 1'b0;
                            state     <= ST_CMD_PG;
                        end else begin
                            byte_valid <= 1'b0;
                            byte_dc    <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
`ifdef OLED_STREAM_CONT_EN
                    page       <= '0;
                    byte_valid <= 1'b1;
                    byte_dc    <= 1'b0;
                    byte_data  <= CMD_SET_PAGE;
                    state      <= ST_CMD_PG;
`else
                    busy  <= 1'b0;
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_page_streamer.sv
// Directed/randomized bench for oled_page_streamer against a frame-order reference model.
module tb_oled_page_streamer;
    import oled_pkg::*;

    localparam int AW = 10;
    localparam int NB = OLED_PAGES * (3 + OLED_COLS);
    localparam int NPIX = OLED_PAGES * OLED_COLS;

    logic          clk = 1'b0;
    logic          rst_n, start, byte_ready;
    logic          busy, frame_done, fb_rd_en, byte_valid, byte_dc;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_rdata, byte_data;
    logic          busy2, frame_done2, fb_rd_en2, byte_valid2, byte_dc2;
    logic [AW-1:0] fb_addr2;
    logic [7:0]    fb_rdata2, byte_data2;

    oled_page_streamer #(.COL_OFFSET(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
        .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc), .byte_ready(byte_ready)
    );

    oled_page_streamer #(.COL_OFFSET(2)) dut_off2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .frame_done(frame_done2),
        .fb_rd_en(fb_rd_en2), .fb_addr(fb_addr2), .fb_rdata(fb_rdata2),
        .byte_valid(byte_valid2), .byte_data(byte_data2), .byte_dc(byte_dc2), .byte_ready(byte_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (fb_rd_en)  fb_rdata  <= mem[fb_addr];
        if (fb_rd_en2) fb_rdata2 <= mem[fb_addr2];
    end

    int vectors = 0;
    int miscompares = 0;
    int ready_pct = 100;
    int done_cnt = 0;
    logic [8:0] cap_q[$];
    logic [8:0] cap2_q[$];
    int addr_q[$];
    logic pend = 1'b0;
    logic [8:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 byte_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Handshake capture and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pend) begin
                chk("hold_valid", byte_valid, 1);
                chk("hold_byte", {byte_dc, byte_data}, held);
            end
            if (byte_valid && byte_ready)   cap_q.push_back({byte_dc, byte_data});
            if (byte_valid2 && byte_ready)  cap2_q.push_back({byte_dc2, byte_data2});
            if (fb_rd_en)                   addr_q.push_back(int'(fb_addr));
            if (frame_done)                 done_cnt++;
            pend = byte_valid && !byte_ready;
            held = {byte_dc, byte_data};
        end else begin
            pend = 1'b0;
        end
    end

    task automatic fill(input bit rnd);
        for (int i = 0; i < 1024; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
    endtask

    task automatic clear_caps();
        cap_q.delete();
        cap2_q.delete();
        addr_q.delete();
        done_cnt = 0;
    endtask

    // Reference: page command, two column commands, then the page's pixels in column order.
    task automatic compare_stream(input string tag, input int off, input int nf, input logic [8:0] q[$]);
        int k;
        logic [8:0] e;
        k = 0;
        chk({tag, "_len"}, q.size(), nf * NB);
        for (int f = 0; f < nf; f++) begin
            for (int p = 0; p < OLED_PAGES; p++) begin
                for (int j = 0; j < 3 + OLED_COLS; j++) begin
                    if (j == 0)      e = {1'b0, 8'(8'hB0 + p)};
                    else if (j == 1) e = {1'b0, 8'(off % 16)};
                    else if (j == 2) e = {1'b0, 8'(8'h10 + off / 16)};
                    else             e = {1'b1, mem[p * OLED_COLS + j - 3]};
                    if (k < q.size()) chk(tag, q[k], e);
                    k++;
                end
            end
        end
    endtask

    task automatic compare_addr(input int nf);
        chk("addr_len", addr_q.size(), nf * NPIX);
        for (int i = 0; i < addr_q.size() && i < nf * NPIX; i++) chk("fb_addr", addr_q[i], i % NPIX);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_fb_rd_en"}, fb_rd_en, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_byte_valid"}, byte_valid, 0);
        chk({tag, "_byte_data"}, byte_data, 0);
        chk({tag, "_byte_dc"}, byte_dc, 0);
    endtask

    task automatic run_frame(input bit extra_start);
        int cyc;
        clear_caps();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 20000) begin
            start = extra_start && (cyc == 300);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("frame_done_pulse", frame_done, 1);
        @(posedge clk); #1;
        chk("frame_done_single", frame_done, 0);
        chk("busy_after_done", busy, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("stays_idle", busy, 0);
        compare_stream("stream", 0, 1, cap_q);
        compare_stream("stream_off2", 2, 1, cap2_q);
        compare_addr(1);
    endtask

    initial begin
        int cyc;
        int busy_low;
        rst_n = 1'b0;
        start = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef OLED_STREAM_CONT_EN
        ready_pct = 100;
        clear_caps();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        busy_low = 0;
        while (done_cnt < 3 && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            if (busy !== 1'b1) busy_low++;
        end
        chk("cont_frames", done_cnt, 3);
        chk("cont_busy_low_cycles", busy_low, 0);
        compare_stream("cont_stream", 0, 3, cap_q);
        compare_addr(3);
`else
        // Unstalled frame, pixel = low address byte.
        ready_pct = 100;
        run_frame(0);
        if (cap_q.size() > 131) begin
            chk("first_cmd_page", cap_q[0], 9'h0B0);
            chk("first_cmd_col_lo", cap_q[1], 9'h000);
            chk("first_cmd_col_hi", cap_q[2], 9'h010);
            chk("first_data0", cap_q[3], 9'h100);
            chk("first_data1", cap_q[4], 9'h101);
            chk("page1_cmd", cap_q[131], 9'h0B1);
        end else begin
            chk("first_frame_short", cap_q.size(), NB);
        end

        // ~30% ready back-pressure, random pixels.
        fill(1);
        ready_pct = 30;
        run_frame(0);

        // Redundant start while busy must be ignored.
        fill(1);
        ready_pct = 60;
        run_frame(1);

        // Reset mid-frame at byte 500.
        ready_pct = 70;
        clear_caps();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cap_q.size() < 500 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reached_byte_500", cap_q.size(), 500);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", busy, 0);

        fill(1);
        ready_pct = 100;
        run_frame(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
